rv32_div_unit: RTL and testbench

- Iterative RV32M divide unit for the single-cycle core.
- Consumes register-file read data (RD1/RD2) and produces a write-back request (address, data, write enable) that feeds the register file write port (A3/WD3/WE3).
- Implements DIV, DIVU, REM and REMU with a radix-2 restoring algorithm.
- Asserts busy so the core stalls its PC while a division is in flight.

---
 rtl/rv32_div_pkg.sv | 26 ++
 rtl/rv32_div_unit_if.sv | 26 ++
 rtl/rv32_div_step.sv | 25 ++
 rtl/rv32_div_unit.sv | 165 ++++++++++++++++
 tb/tb_rv32_div_unit.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_div_pkg.sv
// rv32_div_pkg: shared op encodings, FSM states and RV32 divide constants.
package rv32_div_pkg;

   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } div_op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      CALC  = 2'b01,
      FIXUP = 2'b10,
      DONE  = 2'b11
   } div_state_e;

   localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
   localparam logic [31:0] INT_MIN    = 32'h8000_0000;

   // op[0] clear selects the signed variants (DIV/REM)
   function automatic logic is_signed_op(input logic [1:0] op);
      return (op[0] == 1'b0);
   endfunction

endpackage

// File: rtl/rv32_div_unit_if.sv
// rv32_div_unit_if: request / write-back bundle between the core and the divide unit.
interface rv32_div_unit_if #(
   parameter int DATA_WIDTH        = 32,
   parameter int ADDRESS_BIT_WIDTH = 5
);
   logic                         start;
   logic [1:0]                   op;
   logic [DATA_WIDTH-1:0]        rs1_data;
   logic [DATA_WIDTH-1:0]        rs2_data;
   logic [ADDRESS_BIT_WIDTH-1:0] rd_addr;
   logic                         busy;
   logic                         done;
   logic                         wb_we;
   logic [ADDRESS_BIT_WIDTH-1:0] wb_addr;
   logic [DATA_WIDTH-1:0]        result;

   modport master (
      output start, op, rs1_data, rs2_data, rd_addr,
      input  busy, done, wb_we, wb_addr, result
   );

   modport slave (
      input  start, op, rs1_data, rs2_data, rd_addr,
      output busy, done, wb_we, wb_addr, result
   );
endinterface

// File: rtl/rv32_div_step.sv
// rv32_div_step: one combinational radix-2 restoring iteration (shift in dividend MSB, trial subtract).
module rv32_div_step #(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] rem,
   input  logic                  dvd_msb,
   input  logic [DATA_WIDTH-1:0] dsr,
   output logic [DATA_WIDTH-1:0] rem_next,
   output logic                  q_bit
);
   logic [DATA_WIDTH:0] shifted_s;
   logic [DATA_WIDTH:0] diff_s;

   // W+1-bit trial subtract; the partial remainder never exceeds 2*dsr-1, so the low W bits suffice afterwards
   always_comb begin
      shifted_s = {rem, dvd_msb};
      diff_s    = shifted_s - {1'b0, dsr};
      q_bit     = (shifted_s >= {1'b0, dsr});
      if (q_bit) begin
         rem_next = diff_s[DATA_WIDTH-1:0];
      end else begin
         rem_next = shifted_s[DATA_WIDTH-1:0];
      end
   end
endmodule

// File: rtl/rv32_div_unit.sv
// rv32_div_unit: iterative RV32M DIV/DIVU/REM/REMU unit feeding the register-file write port.
// Define RV32_DIV_EARLY_OUT_EN to finish |rs1| < |rs2| operands straight from IDLE.
module rv32_div_unit
   import rv32_div_pkg::*;
#(
   parameter int DATA_WIDTH        = 32,
   parameter int ADDRESS_BIT_WIDTH = 5,
   parameter int CNT_WIDTH         = 6
) (
   input logic            clk,
   input logic            rstn,
   input logic            en,
   input logic            flush,
   rv32_div_unit_if.slave bus
);
   localparam logic [CNT_WIDTH-1:0]  LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);
   localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [DATA_WIDTH-1:0] ZERO_W   = {DATA_WIDTH{1'b0}};

   div_state_e                   state_r;
   logic [CNT_WIDTH-1:0]         cnt_r;
   logic                         op_rem_r;
   logic                         q_neg_r;
   logic                         r_neg_r;
   logic                         busy_r;
   logic                         done_r;
   logic [DATA_WIDTH-1:0]        dvd_r;
   logic [DATA_WIDTH-1:0]        dsr_r;
   logic [DATA_WIDTH-1:0]        rem_r;
   logic [DATA_WIDTH-1:0]        result_r;
   logic [ADDRESS_BIT_WIDTH-1:0] addr_r;

   logic                  signed_s;
   logic                  s1_s;
   logic                  s2_s;
   logic                  div_zero_s;
   logic                  ovf_s;
   logic                  early_s;
   logic                  special_s;
   logic [DATA_WIDTH-1:0] mag1_s;
   logic [DATA_WIDTH-1:0] mag2_s;
   logic [DATA_WIDTH-1:0] special_res_s;
   logic [DATA_WIDTH-1:0] fix_res_s;
   logic [DATA_WIDTH-1:0] step_rem_s;
   logic                  step_q_s;

   // Operand magnitudes, sign flags and the results of the cases that skip the iteration
   always_comb begin
      signed_s   = is_signed_op(bus.op);
      s1_s       = signed_s & bus.rs1_data[DATA_WIDTH-1];
      s2_s       = signed_s & bus.rs2_data[DATA_WIDTH-1];
      mag1_s     = s1_s ? (ZERO_W - bus.rs1_data) : bus.rs1_data;
      mag2_s     = s2_s ? (ZERO_W - bus.rs2_data) : bus.rs2_data;
      div_zero_s = (bus.rs2_data == ZERO_W);
      ovf_s      = signed_s & (bus.rs1_data == INT_MIN) & (bus.rs2_data == DIV_ZERO_Q);
`ifdef RV32_DIV_EARLY_OUT_EN
      early_s    = ~div_zero_s & ~ovf_s & (mag1_s < mag2_s);
`else
      early_s    = 1'b0;
`endif
      special_s  = div_zero_s | ovf_s | early_s;
      if (div_zero_s) begin
         special_res_s = bus.op[1] ? bus.rs1_data : DIV_ZERO_Q;
      end else if (ovf_s) begin
         special_res_s = bus.op[1] ? ZERO_W : INT_MIN;
      end else begin
         special_res_s = bus.op[1] ? bus.rs1_data : ZERO_W;
      end
   end

   // Sign correction applied once the magnitudes are final
   always_comb begin
      if (op_rem_r) begin
         fix_res_s = r_neg_r ? (ZERO_W - rem_r) : rem_r;
      end else begin
         fix_res_s = q_neg_r ? (ZERO_W - dvd_r) : dvd_r;
      end
   end

   rv32_div_step #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_step (
      .rem      (rem_r),
      .dvd_msb  (dvd_r[DATA_WIDTH-1]),
      .dsr      (dsr_r),
      .rem_next (step_rem_s),
      .q_bit    (step_q_s)
   );

   // Divider FSM; quotient bits shift into dvd_r, which also stages the answer until DONE commits it
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r  <= IDLE;
         cnt_r    <= {CNT_WIDTH{1'b0}};
         op_rem_r <= 1'b0;
         q_neg_r  <= 1'b0;
         r_neg_r  <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         dvd_r    <= ZERO_W;
         dsr_r    <= ZERO_W;
         rem_r    <= ZERO_W;
         result_r <= ZERO_W;
         addr_r   <= {ADDRESS_BIT_WIDTH{1'b0}};
      end else if (en) begin
         done_r <= 1'b0;
         if (flush) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
         end else begin
            case (state_r)
               IDLE: begin
                  // done_r high marks the completion cycle, in which a new start is not taken
                  if (bus.start && !done_r) begin
                     op_rem_r <= bus.op[1];
                     addr_r   <= bus.rd_addr;
                     q_neg_r  <= s1_s ^ s2_s;
                     r_neg_r  <= s1_s;
                     dsr_r    <= mag2_s;
                     rem_r    <= ZERO_W;
                     cnt_r    <= {CNT_WIDTH{1'b0}};
                     busy_r   <= 1'b1;
                     if (special_s) begin
                        dvd_r   <= special_res_s;
                        state_r <= DONE;
                     end else begin
                        dvd_r   <= mag1_s;
                        state_r <= CALC;
                     end
                  end
               end
               CALC: begin
                  rem_r <= step_rem_s;
                  dvd_r <= {dvd_r[DATA_WIDTH-2:0], step_q_s};
                  cnt_r <= cnt_r + CNT_ONE;
                  if (cnt_r == LAST_CNT) begin
                     state_r <= FIXUP;
                  end
               end
               FIXUP: begin
                  dvd_r   <= fix_res_s;
                  state_r <= DONE;
               end
               DONE: begin
                  result_r <= dvd_r;
                  done_r   <= 1'b1;
                  busy_r   <= 1'b0;
                  state_r  <= IDLE;
               end
               default: begin
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
               end
            endcase
         end
      end
   end

   assign bus.busy    = busy_r;
   assign bus.done    = done_r & en;
   assign bus.wb_we   = done_r & en;
   assign bus.wb_addr = addr_r;
   assign bus.result  = result_r;

endmodule

// File: tb/tb_rv32_div_unit.sv
// tb_rv32_div_unit: directed vectors against a latency/arithmetic reference model of the divide unit.
module tb_rv32_div_unit;
   import rv32_div_pkg::*;

`ifdef RV32_DIV_EARLY_OUT_EN
   localparam int EO_LAT = 1;
`else
   localparam int EO_LAT = 34;
`endif

   logic clk   = 1'b0;
   logic rstn  = 1'b0;
   logic en    = 1'b1;
   logic flush = 1'b0;
   int   checks = 0;
   int   errors = 0;

   rv32_div_unit_if bus ();

   rv32_div_unit dut (
      .clk   (clk),
      .rstn  (rstn),
      .en    (en),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // RISC-V M-extension semantics written directly with SV arithmetic
   function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      int sa;
      int sb;
      sa = a;
      sb = b;
      if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
      if (op[0]) return op[1] ? (a % b) : (a / b);
      return op[1] ? 32'(sa % sb) : 32'(sa / sb);
   endfunction

   function automatic int exp_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] ma;
      logic [31:0] mb;
      ma = (!op[0] && a[31]) ? (32'd0 - a) : a;
      mb = (!op[0] && b[31]) ? (32'd0 - b) : b;
      if (b == 32'd0) return 1;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef RV32_DIV_EARLY_OUT_EN
      if (ma < mb) return 1;
`endif
      return (ma == mb) ? 34 : 34;
   endfunction

   // Reference model: accepted request counts down its latency in enabled cycles, then commits
   logic        m_busy;
   logic        m_done;
   int          m_left;
   logic [31:0] m_result;
   logic [31:0] m_pend;
   logic [4:0]  m_addr;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0;
         m_result <= 32'd0; m_pend <= 32'd0; m_addr <= 5'd0;
      end else if (en) begin
         m_done <= 1'b0;
         if (flush) begin
            m_left <= 0; m_busy <= 1'b0;
         end else if (m_left > 1) begin
            m_left <= m_left - 1;
         end else if (m_left == 1) begin
            m_left <= 0; m_done <= 1'b1; m_busy <= 1'b0; m_result <= m_pend;
         end else if (bus.start && !m_done) begin
            m_left <= exp_latency(bus.op, bus.rs1_data, bus.rs2_data);
            m_busy <= 1'b1;
            m_addr <= bus.rd_addr;
            m_pend <= ref_result(bus.op, bus.rs1_data, bus.rs2_data);
         end
      end
   end

   always @(negedge clk) begin
      check("cmp_busy", bus.busy, m_busy);
      check("cmp_done", bus.done, m_done & en);
      check("cmp_wb_we", bus.wb_we, m_done & en);
      if (!m_busy) begin
         check("cmp_result", bus.result, m_result);
         check("cmp_wb_addr", bus.wb_addr, m_addr);
      end
   end

   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input int exp_lat,
                         input int gap_at, input int gap_len, input string name);
      int lat;
      bit got;
      check({name, "_model"}, ref_result(op, a, b), exp);
      @(negedge clk);
      bus.start = 1'b1; bus.op = op; bus.rs1_data = a; bus.rs2_data = b; bus.rd_addr = rd;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      got = 1'b0;
      lat = 0;
      for (int k = 1; k <= 100 && !got; k++) begin
         @(posedge clk);
         #1;
         if (k == gap_at) en = 1'b0;
         if (k == gap_at + gap_len) en = 1'b1;
         if (bus.done) begin
            got = 1'b1;
            lat = k;
         end
      end
      check({name, "_latency"}, lat, exp_lat);
      check({name, "_result"}, bus.result, exp);
      check({name, "_wb_addr"}, bus.wb_addr, rd);
      check({name, "_wb_we"}, bus.wb_we, 1'b1);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ndone;
      logic [31:0] got_res;
      logic [4:0]  got_addr;
      bus.start = 1'b0; bus.op = 2'b00; bus.rs1_data = 32'd0; bus.rs2_data = 32'd0; bus.rd_addr = 5'd0;
      repeat (2) @(negedge clk);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_done", bus.done, 1'b0);
      check("rst_wb_we", bus.wb_we, 1'b0);
      check("rst_result", bus.result, 32'd0);
      check("rst_wb_addr", bus.wb_addr, 5'd0);
      rstn = 1'b1;

      run_op(OP_DIVU, 32'd100,          32'd7,          5'd5,  32'd14,          34,     0, 0, "divu_100_7");
      run_op(OP_REMU, 32'd100,          32'd7,          5'd6,  32'd2,           34,     0, 0, "remu_100_7");
      run_op(OP_DIV,  32'hFFFF_FFF9,    32'd2,          5'd7,  32'hFFFF_FFFD,   34,     0, 0, "div_m7_2");
      run_op(OP_REM,  32'hFFFF_FFF9,    32'd2,          5'd8,  32'hFFFF_FFFF,   34,     0, 0, "rem_m7_2");
      run_op(OP_REM,  32'd7,            32'hFFFF_FFFE,  5'd9,  32'd1,           34,     0, 0, "rem_7_m2");
      run_op(OP_DIV,  32'd5,            32'd0,          5'd1,  32'hFFFF_FFFF,   1,      0, 0, "div_5_0");
      run_op(OP_REMU, 32'd5,            32'd0,          5'd2,  32'd5,           1,      0, 0, "remu_5_0");
      run_op(OP_DIV,  32'h8000_0000,    32'hFFFF_FFFF,  5'd3,  32'h8000_0000,   1,      0, 0, "div_ovf");
      run_op(OP_REM,  32'h8000_0000,    32'hFFFF_FFFF,  5'd4,  32'd0,           1,      0, 0, "rem_ovf");
      run_op(OP_DIVU, 32'd3,            32'd10,         5'd10, 32'd0,           EO_LAT, 0, 0, "divu_3_10");
      run_op(OP_REM,  32'hFFFF_FFFD,    32'd10,         5'd11, 32'hFFFF_FFFD,   EO_LAT, 0, 0, "rem_m3_10");
      run_op(OP_DIV,  32'h7FFF_FFFF,    32'hFFFF_FFFD,  5'd12, 32'hD555_5556,   34,     0, 0, "div_max_m3");
      run_op(OP_DIVU, 32'hFFFF_FFFF,    32'hFFFF_FFFF,  5'd13, 32'd1,           34,     0, 0, "divu_all1");
      run_op(OP_REMU, 32'hFFFF_FFFF,    32'h0000_0010,  5'd14, 32'h0000_000F,   34,     0, 0, "remu_all1_16");

      // A start presented during the completion pulse is dropped
      bus.start = 1'b1; bus.op = OP_DIVU; bus.rs1_data = 32'd9; bus.rs2_data = 32'd3; bus.rd_addr = 5'd15;
      @(posedge clk);
      #1;
      check("start_in_done_ignored", bus.busy, 1'b0);
      @(negedge clk);
      bus.start = 1'b0;

      // A second start while busy is neither queued nor completed
      @(negedge clk);
      bus.start = 1'b1; bus.op = OP_DIVU; bus.rs1_data = 32'd200; bus.rs2_data = 32'd9; bus.rd_addr = 5'd10;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      bus.start = 1'b1; bus.op = OP_DIV; bus.rs1_data = 32'd50; bus.rs2_data = 32'd5; bus.rd_addr = 5'd11;
      @(negedge clk);
      bus.start = 1'b0;
      ndone = 0; got_res = 32'd0; got_addr = 5'd0;
      for (int k = 0; k < 60; k++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            ndone++;
            got_res = bus.result;
            got_addr = bus.wb_addr;
         end
      end
      check("busy_start_done_count", ndone, 1);
      check("busy_start_result", got_res, 32'd22);
      check("busy_start_wb_addr", got_addr, 5'd10);

      // Flush sampled at edge 10 aborts without write-back
      @(negedge clk);
      bus.start = 1'b1; bus.op = OP_DIVU; bus.rs1_data = 32'd1000; bus.rs2_data = 32'd3; bus.rd_addr = 5'd12;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      check("flush_busy", bus.busy, 1'b0);
      @(negedge clk);
      flush = 1'b0;
      ndone = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (bus.done || bus.wb_we) ndone++;
      end
      check("flush_no_done", ndone, 0);
      check("flush_result_kept", bus.result, 32'd22);

      // Reset pulse in the middle of CALC
      @(negedge clk);
      bus.start = 1'b1; bus.op = OP_DIVU; bus.rs1_data = 32'd1000; bus.rs2_data = 32'd7; bus.rd_addr = 5'd13;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rstn = 1'b0;
      #1;
      check("midrst_busy", bus.busy, 1'b0);
      check("midrst_done", bus.done, 1'b0);
      check("midrst_wb_we", bus.wb_we, 1'b0);
      check("midrst_result", bus.result, 32'd0);
      check("midrst_wb_addr", bus.wb_addr, 5'd0);
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      run_op(OP_REMU, 32'd1000,         32'd7,          5'd14, 32'd6,           34,     0, 0, "remu_after_rst");

      // Five disabled cycles mid-CALC stretch the latency by five
      run_op(OP_DIVU, 32'd100,          32'd7,          5'd3,  32'd14,          39,    10, 5, "divu_en_gap");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
